// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, state codes and
// the datapath select encodings driven by the FSM.
package multicycle_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_I   = 2'b01,
      ALU_R   = 2'b10,
      ALU_B   = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_BRANCH = 2'b01,
      PC_ALU    = 2'b10
   } pc_src_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_MEM  = 2'b01,
      WB_PC4  = 2'b10,
      WB_UIMM = 2'b11
   } wb_sel_e;

   typedef struct packed {
      logic    supported;
      logic    is_branch;
      logic    is_load;
      logic    is_store;
      logic    is_jump;
      alu_op_e alu_op;
      logic    alu_src_b;
      wb_sel_e wb_sel;
   } decode_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode classification for the multicycle controller: instruction class,
// ALU operation/operand select for EXEC and write-back source for WB.
module mc_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output decode_t    dec
);

   always_comb begin
      dec           = '0;
      dec.supported = 1'b1;
      dec.alu_op    = ALU_ADD;
      dec.alu_src_b = 1'b1;
      dec.wb_sel    = WB_ALU;
      case (opcode)
         OP_R: begin
            dec.alu_op    = ALU_R;
            dec.alu_src_b = 1'b0;
         end
         OP_I:     dec.alu_op = ALU_I;
         OP_LOAD: begin
            dec.is_load = 1'b1;
            dec.wb_sel  = WB_MEM;
         end
         OP_STORE: dec.is_store = 1'b1;
         OP_BRANCH: begin
            dec.is_branch = 1'b1;
            dec.alu_op    = ALU_B;
            dec.alu_src_b = 1'b0;
         end
         OP_JAL, OP_JALR: begin
            dec.is_jump = 1'b1;
            dec.wb_sel  = WB_PC4;
         end
         OP_LUI:   dec.wb_sel = WB_UIMM;
         OP_AUIPC: dec.wb_sel = WB_ALU;
         default:  dec.supported = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer. Defining MC_MEMWAIT_TIMEOUT_EN adds an
// 8-bit memory-wait watchdog that traps with a sticky mem_err.
//
//   state  | meaning
//   FETCH  | read instruction at PC, latch IR and PC+4 on mem_ready
//   DECODE | classify opcode, trap if unsupported
//   EXEC   | ALU op; branches retire here, jumps write PC
//   MEM    | data load/store at ALU address until mem_ready
//   WB     | register-file write, retire
//   TRAP   | halted until rst (codes 6/7 also land here)
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       func7,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic       reg_we,
   output logic [1:0] pc_src,
   output logic [1:0] wb_sel,
   output logic       alu_src_b,
   output logic [1:0] alu_op,
   output logic       instr_done,
   output logic       halted,
   output logic       mem_err,
   output logic [2:0] state
);

   state_e  state_q;
   state_e  state_d;
   decode_t dec;
   logic    timeout_hit;
   logic    unused_funct;

   // func3/func7 only refine the ALU function downstream; sequencing is opcode-driven
   assign unused_funct = ^{func3, func7};

   mc_decode u_decode (
      .opcode (opcode),
      .dec    (dec)
   );

`ifdef MC_MEMWAIT_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       mem_err_q;
   logic       req_active;

   assign req_active  = (state_q == ST_FETCH) || (state_q == ST_MEM);
   // the wait that takes the counter to 255 is the one that traps
   assign timeout_hit = req_active && !mem_ready && (wait_cnt == 8'hFE);

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         mem_err_q <= 1'b0;
      end else if (req_active) begin
         if (mem_ready) wait_cnt <= '0;
         else           wait_cnt <= wait_cnt + 8'd1;
         if (timeout_hit) mem_err_q <= 1'b1;
      end
   end

   assign mem_err = mem_err_q && !rst;
`else
   assign timeout_hit = 1'b0;
   assign mem_err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   assign state = rst ? 3'd0 : state_q;

   always_comb begin
      state_d      = state_q;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      reg_we       = 1'b0;
      pc_src       = PC_PLUS4;
      wb_sel       = WB_ALU;
      alu_src_b    = 1'b0;
      alu_op       = ALU_ADD;
      instr_done   = 1'b0;
      halted       = 1'b0;

      case (state_q)
         ST_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = dec.supported ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            alu_op    = dec.alu_op;
            alu_src_b = dec.alu_src_b;
            if (dec.is_branch) begin
               pc_we      = branch_taken;
               pc_src     = PC_BRANCH;
               instr_done = 1'b1;
               state_d    = ST_FETCH;
            end else if (dec.is_load || dec.is_store) begin
               state_d = ST_MEM;
            end else if (dec.is_jump) begin
               pc_we   = 1'b1;
               pc_src  = PC_ALU;
               state_d = ST_WB;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            mem_addr_sel = 1'b1;
            mem_rd       = dec.is_load;
            mem_wr       = dec.is_store;
            if (mem_ready) begin
               instr_done = dec.is_store;
               state_d    = dec.is_store ? ST_FETCH : ST_WB;
            end
         end
         ST_WB: begin
            reg_we     = 1'b1;
            instr_done = 1'b1;
            wb_sel     = dec.wb_sel;
            state_d    = ST_FETCH;
         end
         ST_TRAP: halted = 1'b1;
         default: state_d = ST_TRAP;
      endcase

      if (timeout_hit) state_d = ST_TRAP;

      // outputs are forced quiet for the whole reset cycle, not just after it
      if (rst) begin
         mem_rd       = 1'b0;
         mem_wr       = 1'b0;
         mem_addr_sel = 1'b0;
         ir_we        = 1'b0;
         pc_we        = 1'b0;
         reg_we       = 1'b0;
         pc_src       = PC_PLUS4;
         wb_sel       = WB_ALU;
         alu_src_b    = 1'b0;
         alu_op       = ALU_ADD;
         instr_done   = 1'b0;
         halted       = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: random instruction stream and memory
// waits, with per-instruction expectations from a behavioural latency model.
module tb_multicycle_ctrl;

   localparam logic [6:0] R_OP  = 7'b0110011;
   localparam logic [6:0] I_OP  = 7'b0010011;
   localparam logic [6:0] LD_OP = 7'b0000011;
   localparam logic [6:0] ST_OP = 7'b0100011;
   localparam logic [6:0] BR_OP = 7'b1100011;
   localparam logic [6:0] JL_OP = 7'b1101111;
   localparam logic [6:0] JR_OP = 7'b1100111;
   localparam logic [6:0] LU_OP = 7'b0110111;
   localparam logic [6:0] AU_OP = 7'b0010111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic [2:0] func3 = 3'd0;
   logic       func7 = 1'b0;
   logic       branch_taken = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_rd, mem_wr, mem_addr_sel, ir_we, pc_we, reg_we;
   logic [1:0] pc_src, wb_sel, alu_op;
   logic       alu_src_b, instr_done, halted, mem_err;
   logic [2:0] state;
   logic [18:0] outs;

   assign outs = {mem_rd, mem_wr, mem_addr_sel, ir_we, pc_we, reg_we, pc_src, wb_sel,
                  alu_src_b, alu_op, instr_done, halted, mem_err, state};

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr_sel(mem_addr_sel),
      .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src),
      .wb_sel(wb_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .instr_done(instr_done), .halted(halted), .mem_err(mem_err), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lat; int frd; int drd; int dwr;
      int pcx; int pcx_src; int rw; int wbs;
      bit chk_alu; int aop; bit chk_asb; int asb;
   } exp_t;

   exp_t sb[$];
   int   wq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   both_cnt = 0;
   logic [6:0] ops [9] = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JL_OP, JR_OP, LU_OP, AU_OP};

   function automatic void check(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, want);
      end
   endfunction

   // Expectations from the instruction-class latency and side-effect rules
   function automatic exp_t model(input logic [6:0] op, input bit tk, input int fw, input int mw);
      exp_t e;
      bit br, ld, st, jp;
      br = (op == BR_OP);
      ld = (op == LD_OP);
      st = (op == ST_OP);
      jp = (op == JL_OP) || (op == JR_OP);
      e.lat     = (br ? 3 : (ld ? 5 : 4)) + fw + ((ld || st) ? mw : 0);
      e.frd     = fw + 1;
      e.drd     = ld ? mw + 1 : 0;
      e.dwr     = st ? mw + 1 : 0;
      e.pcx     = (jp || (br && tk)) ? 1 : 0;
      e.pcx_src = jp ? 2 : 1;
      e.rw      = (br || st) ? 0 : 1;
      e.wbs     = ld ? 1 : (jp ? 2 : ((op == LU_OP) ? 3 : 0));
      e.chk_alu = br || ld || st || (op == R_OP) || (op == I_OP);
      e.aop     = br ? 3 : ((op == R_OP) ? 2 : ((op == I_OP) ? 1 : 0));
      e.chk_asb = ld || st;
      e.asb     = 1;
      return e;
   endfunction

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // Memory responder: honours queued wait counts, random stray ready otherwise
   initial begin
      bit active = 0;
      int rem = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            active = 0;
            mem_ready = 1'b0;
         end else if (mem_rd || mem_wr) begin
            if (!active) begin
               active = 1;
               rem = 0;
               if (wq.size() > 0) rem = wq.pop_front();
            end
            if (rem == 0) begin
               mem_ready = 1'b1;
               active = 0;
            end else begin
               mem_ready = 1'b0;
               rem--;
            end
         end else begin
            active = 0;
            mem_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: accumulates one instruction's activity and scores it on retire
   initial begin
      int cyc = 0, frd = 0, drd = 0, dwr = 0, irw = 0, pcf = 0, pcx = 0, pcx_src = 0;
      int rw = 0, wbs = 0, aop = 0, asb = 0;
      exp_t e;
      forever begin
         tick();
         if (rst) begin
            cyc = 0; frd = 0; drd = 0; dwr = 0; irw = 0; pcf = 0; pcx = 0; rw = 0;
            continue;
         end
         cyc++;
         if (mem_rd && mem_wr) both_cnt++;
         if (ir_we) irw++;
         if (pc_we) begin
            if (pc_src == 2'b00) pcf++;
            else begin
               pcx++;
               pcx_src = int'(pc_src);
            end
         end
         if (reg_we) begin
            rw++;
            wbs = int'(wb_sel);
         end
         if (mem_rd && !mem_addr_sel) frd++;
         if (mem_rd && mem_addr_sel) drd++;
         if (mem_wr) dwr++;
         if (state == 3'd2) begin
            aop = int'(alu_op);
            asb = int'(alu_src_b);
         end
         if (instr_done) begin
            check("sb_depth_at_retire", sb.size(), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("latency", cyc, e.lat);
               check("fetch_rd_cycles", frd, e.frd);
               check("data_rd_cycles", drd, e.drd);
               check("data_wr_cycles", dwr, e.dwr);
               check("ir_we_count", irw, 1);
               check("fetch_pc_we_count", pcf, 1);
               check("exec_pc_we_count", pcx, e.pcx);
               if (e.pcx > 0) check("exec_pc_src", pcx_src, e.pcx_src);
               check("reg_we_count", rw, e.rw);
               if (e.rw > 0) check("wb_sel", wbs, e.wbs);
               if (e.chk_alu) check("alu_op", aop, e.aop);
               if (e.chk_asb) check("alu_src_b", asb, e.asb);
            end
            cyc = 0; frd = 0; drd = 0; dwr = 0; irw = 0; pcf = 0; pcx = 0; rw = 0;
         end
      end
   end

   task automatic do_reset(input int n);
      #1;
      rst = 1'b1;
      #1;
      check("rst_outs_entry", int'(outs), 0);
      for (int i = 0; i < n; i++) begin
         tick();
         check("rst_outs_hold", int'(outs), 0);
      end
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_state", int'(state), 0);
      check("post_rst_fetch_rd", int'(mem_rd), 1);
      check("post_rst_halted", int'(halted), 0);
      check("post_rst_mem_err", int'(mem_err), 0);
   endtask

   task automatic run_instr(input logic [6:0] op, input bit tk, input int fw, input int mw);
      bit seen = 0;
      wq.push_back(fw);
      if (op == LD_OP || op == ST_OP) wq.push_back(mw);
      sb.push_back(model(op, tk, fw, mw));
      for (int i = 0; i < 60; i++) begin
         tick();
         if (ir_we) begin
            seen = 1;
            break;
         end
      end
      check("ir_we_seen", int'(seen), 1);
      opcode = op;
      func3 = 3'($urandom_range(0, 7));
      func7 = 1'($urandom_range(0, 1));
      branch_taken = tk;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (instr_done) begin
            seen = 1;
            break;
         end
      end
      check("instr_done_seen", int'(seen), 1);
   endtask

   task automatic reset_during_fetch();
      int seen = 0;
      wq.push_back(10);
      for (int i = 0; i < 20 && seen < 3; i++) begin
         tick();
         if (mem_rd && !mem_addr_sel) seen++;
      end
      check("fetch_wait_seen", seen, 3);
      do_reset(1);
   endtask

   task automatic run_trap();
      bit seen = 0;
      wq.push_back(0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ir_we) begin
            seen = 1;
            break;
         end
      end
      check("trap_fetch_seen", int'(seen), 1);
      opcode = 7'b0000000;
      tick();
      check("trap_decode_state", int'(state), 1);
      tick();
      check("trap_state", int'(state), 5);
      for (int i = 0; i < 20; i++) begin
         check("trap_halted", int'(halted), 1);
         check("trap_enables_zero", int'({mem_rd, mem_wr, ir_we, pc_we, reg_we, instr_done}), 0);
         tick();
      end
      do_reset(2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(3);
      run_instr(R_OP, 1'b0, 0, 0);
      run_instr(LD_OP, 1'b0, 0, 2);
      run_instr(BR_OP, 1'b1, 0, 0);
      run_instr(BR_OP, 1'b0, 0, 0);
      run_instr(ST_OP, 1'b0, 0, 0);
      run_instr(JL_OP, 1'b0, 0, 0);
      run_instr(LU_OP, 1'b0, 1, 0);
      for (int k = 0; k < 40; k++) begin
         run_instr(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      reset_during_fetch();
      run_instr(R_OP, 1'b0, 0, 0);
      run_trap();
      run_instr(I_OP, 1'b0, 2, 0);
`ifdef MC_MEMWAIT_TIMEOUT_EN
      begin
         int n = 0;
         bit trapped = 0;
         wq.push_back(1000000);
         for (int i = 0; i < 400; i++) begin
            tick();
            if (state == 3'd5) begin
               trapped = 1;
               break;
            end
            if (mem_rd) n++;
         end
         check("timeout_trapped", int'(trapped), 1);
         check("timeout_wait_cycles", n, 255);
         check("timeout_mem_err", int'(mem_err), 1);
         check("timeout_halted", int'(halted), 1);
         do_reset(2);
         run_instr(R_OP, 1'b0, 0, 0);
      end
`endif
      tick();
      tick();
      check("sb_empty", sb.size(), 0);
      check("rd_wr_overlap", both_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
